// File: rtl/ex_pkg.sv
// Shared definitions for the RV32IM execute stage: widths, opcodes, operation classes and FSM states.
package ex_pkg;

  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;
  localparam int AddrLen    = 32;
  localparam int OpCodeLen  = 6;
  localparam int OpSelLen   = 3;
  localparam int StallLen   = 6;

  typedef enum logic [OpCodeLen-1:0] {
    EXE_NOP,
    EXE_LUI, EXE_AUIPC, EXE_JAL, EXE_JALR,
    EXE_BEQ, EXE_BNE, EXE_BLT, EXE_BGE, EXE_BLTU, EXE_BGEU,
    EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU,
    EXE_SB, EXE_SH, EXE_SW,
    EXE_ADDI, EXE_SLTI, EXE_SLTIU, EXE_XORI, EXE_ORI, EXE_ANDI,
    EXE_SLLI, EXE_SRLI, EXE_SRAI,
    EXE_ADD, EXE_SUB, EXE_SLL, EXE_SLT, EXE_SLTU, EXE_XOR,
    EXE_SRL, EXE_SRA, EXE_OR, EXE_AND,
    EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU,
    EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU
  } aluop_e;

  typedef enum logic [OpSelLen-1:0] {
    SEL_NOP, SEL_LOGIC, SEL_SHIFT, SEL_ARITH, SEL_JUMP, SEL_MEM, MULDIV_OP
  } alusel_e;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_MUL  = 2'd1,
    EX_DIV  = 2'd2,
    EX_DONE = 2'd3
  } ex_state_e;

  function automatic logic isMulOp(input logic [OpCodeLen-1:0] op);
    return op inside {EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU};
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit per ready cycle.
module ex_divider #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CntW = $clog2(DIV_CYCLES);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [CntW-1:0] r_count;
  logic            r_busy;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_remNext;
  logic [XLEN-1:0] w_quoNext;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_fits    = ~w_diff[XLEN];
  assign w_remNext = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quoNext = {r_quo[XLEN-2:0], w_fits};

  // Outputs expose the result of the step in flight so the caller can finish on the last edge.
  assign o_busy      = r_busy;
  assign o_done      = r_busy & (r_count == CntW'(DIV_CYCLES - 1));
  assign o_quotient  = w_quoNext;
  assign o_remainder = w_remNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (rdy) begin
      if (i_start) begin
        r_rem   <= '0;
        r_quo   <= i_dividend;
        r_div   <= i_divisor;
        r_count <= '0;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_rem   <= w_remNext;
        r_quo   <= w_quoNext;
        r_count <= r_count + CntW'(1);
        if (o_done) r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex.sv
// RV32IM execute stage: single-cycle ALU/branch logic plus an FSM-driven multiply/divide unit.
// Optional branch statistics counters are built when EX_BRANCH_STATS_EN is defined.
module ex
  import ex_pkg::*;
#(
  parameter int XLEN       = RegLen,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [StallLen-1:0]   stall,
  input  logic [RegLen-1:0]     ex_reg1,
  input  logic [RegLen-1:0]     ex_reg2,
  input  logic [RegLen-1:0]     ex_Imm,
  input  logic [RegAddrLen-1:0] ex_rd,
  input  logic                  ex_rd_enable,
  input  logic [OpCodeLen-1:0]  ex_aluop,
  input  logic [OpSelLen-1:0]   ex_alusel,
  input  logic [AddrLen-1:0]    ex_pc,
  input  logic                  jump_i,
  output logic [RegLen-1:0]     rd_data_o,
  output logic [RegAddrLen-1:0] rd_o,
  output logic                  rd_enable_o,
  output logic [AddrLen-1:0]    mem_addr_o,
  output logic [RegLen-1:0]     mem_wdata_o,
  output logic [OpCodeLen-1:0]  aluop_o,
  output logic                  jump_mistake,
  output logic [AddrLen-1:0]    jump_target,
  output logic                  stall_req
`ifdef EX_BRANCH_STATS_EN
  ,
  output logic [RegLen-1:0]     br_count_o,
  output logic [RegLen-1:0]     mispredict_count_o
`endif
);

  ex_state_e       r_state;
  logic [XLEN-1:0] r_result;
  logic            r_isRem;
  logic            r_negQ;
  logic            r_negR;

  logic            w_isMd, w_isMul, w_isDiv, w_isJump;
  logic            w_divSigned, w_isRemOp, w_divZero, w_divOvf, w_divSpecial;
  logic            w_signA, w_signB;
  logic [XLEN-1:0] w_absA, w_absB, w_specialRes;
  logic            w_startMul, w_startDiv;
  logic            w_divBusy, w_divDone;
  logic [XLEN-1:0] w_quo, w_rem, w_divRes;
  logic            w_mulASigned, w_mulBSigned;
  logic signed [2*XLEN+1:0] w_mulA, w_mulB, w_prod;
  logic [XLEN-1:0] w_mulRes;
  logic [XLEN-1:0] w_opB, w_aluRes, w_sumImm;
  logic [4:0]      w_shamt;
  logic            w_taken;
  logic [AddrLen-1:0] w_target, w_pcPlus4;
  logic            w_unused;

  assign w_isMd   = (ex_alusel == MULDIV_OP);
  assign w_isJump = (ex_alusel == SEL_JUMP);
  assign w_isMul  = w_isMd & isMulOp(ex_aluop);
  assign w_isDiv  = w_isMd & ~isMulOp(ex_aluop);

  // Divide-by-zero and signed overflow have fixed answers and never enter the iterative path.
  assign w_divSigned  = ex_aluop inside {EXE_DIV, EXE_REM};
  assign w_isRemOp    = ex_aluop inside {EXE_REM, EXE_REMU};
  assign w_divZero    = (ex_reg2 == '0);
  assign w_divOvf     = w_divSigned & (ex_reg1 == {1'b1, {(XLEN-1){1'b0}}}) & (&ex_reg2);
  assign w_divSpecial = w_divZero | w_divOvf;
  assign w_specialRes = w_divZero ? (w_isRemOp ? ex_reg1 : '1) : (w_isRemOp ? '0 : ex_reg1);

  assign w_signA = w_divSigned & ex_reg1[XLEN-1];
  assign w_signB = w_divSigned & ex_reg2[XLEN-1];
  assign w_absA  = w_signA ? -ex_reg1 : ex_reg1;
  assign w_absB  = w_signB ? -ex_reg2 : ex_reg2;

  assign w_startMul = (r_state == EX_IDLE) & w_isMul;
  assign w_startDiv = (r_state == EX_IDLE) & w_isDiv & ~w_divSpecial;

  ex_divider #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .i_start     (w_startDiv),
    .i_dividend  (w_absA),
    .i_divisor   (w_absB),
    .o_busy      (w_divBusy),
    .o_done      (w_divDone),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_divRes = r_isRem ? (r_negR ? -w_rem : w_rem) : (r_negQ ? -w_quo : w_quo);

  // One 33x33 signed multiply covers all four variants via per-operand sign extension.
  assign w_mulASigned = ex_aluop inside {EXE_MULH, EXE_MULHSU};
  assign w_mulBSigned = (ex_aluop == EXE_MULH);
  assign w_mulA   = {{(XLEN+2){w_mulASigned & ex_reg1[XLEN-1]}}, ex_reg1};
  assign w_mulB   = {{(XLEN+2){w_mulBSigned & ex_reg2[XLEN-1]}}, ex_reg2};
  assign w_prod   = w_mulA * w_mulB;
  assign w_mulRes = (ex_aluop == EXE_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_opB     = (ex_aluop inside {EXE_ADDI, EXE_SLTI, EXE_SLTIU, EXE_XORI, EXE_ORI,
                                       EXE_ANDI, EXE_SLLI, EXE_SRLI, EXE_SRAI}) ? ex_Imm : ex_reg2;
  assign w_shamt   = w_opB[4:0];
  assign w_sumImm  = ex_reg1 + ex_Imm;
  assign w_pcPlus4 = ex_pc + AddrLen'(4);

  always_comb begin
    w_aluRes = '0;
    case (ex_aluop)
      EXE_LUI:             w_aluRes = ex_Imm;
      EXE_AUIPC:           w_aluRes = ex_pc + ex_Imm;
      EXE_JAL, EXE_JALR:   w_aluRes = w_pcPlus4;
      EXE_ADD, EXE_ADDI:   w_aluRes = ex_reg1 + w_opB;
      EXE_SUB:             w_aluRes = ex_reg1 - ex_reg2;
      EXE_SLT, EXE_SLTI:   w_aluRes = {{(XLEN-1){1'b0}}, $signed(ex_reg1) < $signed(w_opB)};
      EXE_SLTU, EXE_SLTIU: w_aluRes = {{(XLEN-1){1'b0}}, ex_reg1 < w_opB};
      EXE_XOR, EXE_XORI:   w_aluRes = ex_reg1 ^ w_opB;
      EXE_OR, EXE_ORI:     w_aluRes = ex_reg1 | w_opB;
      EXE_AND, EXE_ANDI:   w_aluRes = ex_reg1 & w_opB;
      EXE_SLL, EXE_SLLI:   w_aluRes = ex_reg1 << w_shamt;
      EXE_SRL, EXE_SRLI:   w_aluRes = ex_reg1 >> w_shamt;
      EXE_SRA, EXE_SRAI:   w_aluRes = $signed(ex_reg1) >>> w_shamt;
      default:             w_aluRes = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (ex_aluop)
      EXE_BEQ:            w_taken = (ex_reg1 == ex_reg2);
      EXE_BNE:            w_taken = (ex_reg1 != ex_reg2);
      EXE_BLT:            w_taken = ($signed(ex_reg1) < $signed(ex_reg2));
      EXE_BGE:            w_taken = ($signed(ex_reg1) >= $signed(ex_reg2));
      EXE_BLTU:           w_taken = (ex_reg1 < ex_reg2);
      EXE_BGEU:           w_taken = (ex_reg1 >= ex_reg2);
      EXE_JAL, EXE_JALR:  w_taken = 1'b1;
      default:            w_taken = 1'b0;
    endcase
  end

  assign w_target = (ex_aluop == EXE_JALR) ? {w_sumImm[XLEN-1:1], 1'b0} : ex_pc + ex_Imm;

  // Reset forces every output to its idle value even though the datapath is combinational.
  always_comb begin
    rd_data_o    = '0;
    rd_o         = '0;
    rd_enable_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    aluop_o      = EXE_NOP;
    jump_mistake = 1'b0;
    jump_target  = '0;
    stall_req    = 1'b0;
    if (!rst) begin
      rd_o         = ex_rd;
      rd_enable_o  = ex_rd_enable;
      mem_addr_o   = w_sumImm;
      mem_wdata_o  = ex_reg2;
      aluop_o      = ex_aluop;
      stall_req    = w_startMul | w_startDiv | (r_state == EX_MUL) | (r_state == EX_DIV);
      jump_target  = w_taken ? w_target : w_pcPlus4;
      jump_mistake = w_isJump & ((w_taken != jump_i) | (ex_aluop == EXE_JALR)) & ~stall_req;
      if (r_state == EX_DONE)
        rd_data_o = r_result;
      else if (w_isMd)
        rd_data_o = (w_isDiv & w_divSpecial & (r_state == EX_IDLE)) ? w_specialRes : '0;
      else
        rd_data_o = w_aluRes;
    end
  end

  // DONE waits out a held EX/MEM so the op still sitting in ID/EX is not issued a second time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EX_IDLE;
      r_result <= '0;
      r_isRem  <= 1'b0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
    end else if (rdy) begin
      case (r_state)
        EX_IDLE: begin
          if (w_startMul) begin
            r_state <= EX_MUL;
          end else if (w_startDiv) begin
            r_isRem <= w_isRemOp;
            r_negQ  <= w_signA ^ w_signB;
            r_negR  <= w_signA;
            r_state <= EX_DIV;
          end
        end
        EX_MUL: begin
          r_result <= w_mulRes;
          r_state  <= EX_DONE;
        end
        EX_DIV: begin
          if (w_divDone) begin
            r_result <= w_divRes;
            r_state  <= EX_DONE;
          end
        end
        EX_DONE: begin
          if (!stall[3]) r_state <= EX_IDLE;
        end
        default: r_state <= EX_IDLE;
      endcase
    end
  end

`ifdef EX_BRANCH_STATS_EN
  logic [RegLen-1:0] r_brCount;
  logic [RegLen-1:0] r_mispredictCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_brCount         <= '0;
      r_mispredictCount <= '0;
    end else if (rdy && w_isJump && !stall_req) begin
      r_brCount <= r_brCount + RegLen'(1);
      if (jump_mistake) r_mispredictCount <= r_mispredictCount + RegLen'(1);
    end
  end

  assign br_count_o         = r_brCount;
  assign mispredict_count_o = r_mispredictCount;
`endif

  assign w_unused = ^{stall[StallLen-1:4], stall[2:0], w_prod[2*XLEN+1:2*XLEN], w_divBusy};

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the ex stage: ALU, branches, M-extension latency, rdy, reset and stall hold.
module tb_ex;
  import ex_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rdy;
  logic [StallLen-1:0]   stall;
  logic [RegLen-1:0]     ex_reg1, ex_reg2, ex_Imm;
  logic [RegAddrLen-1:0] ex_rd;
  logic                  ex_rd_enable;
  logic [OpCodeLen-1:0]  ex_aluop;
  logic [OpSelLen-1:0]   ex_alusel;
  logic [AddrLen-1:0]    ex_pc;
  logic                  jump_i;
  logic [RegLen-1:0]     rd_data_o;
  logic [RegAddrLen-1:0] rd_o;
  logic                  rd_enable_o;
  logic [AddrLen-1:0]    mem_addr_o;
  logic [RegLen-1:0]     mem_wdata_o;
  logic [OpCodeLen-1:0]  aluop_o;
  logic                  jump_mistake;
  logic [AddrLen-1:0]    jump_target;
  logic                  stall_req;
`ifdef EX_BRANCH_STATS_EN
  logic [RegLen-1:0]     br_count_o;
  logic [RegLen-1:0]     mispredict_count_o;
`endif

  int nChecks = 0;
  int nErrors = 0;
  int cycles;

  ex dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall        (stall),
    .ex_reg1      (ex_reg1),
    .ex_reg2      (ex_reg2),
    .ex_Imm       (ex_Imm),
    .ex_rd        (ex_rd),
    .ex_rd_enable (ex_rd_enable),
    .ex_aluop     (ex_aluop),
    .ex_alusel    (ex_alusel),
    .ex_pc        (ex_pc),
    .jump_i       (jump_i),
    .rd_data_o    (rd_data_o),
    .rd_o         (rd_o),
    .rd_enable_o  (rd_enable_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .aluop_o      (aluop_o),
    .jump_mistake (jump_mistake),
    .jump_target  (jump_target),
    .stall_req    (stall_req)
`ifdef EX_BRANCH_STATS_EN
    ,
    .br_count_o         (br_count_o),
    .mispredict_count_o (mispredict_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OpCodeLen-1:0] op;
    logic [OpSelLen-1:0]  sel;
    logic [31:0]          r1;
    logic [31:0]          r2;
    logic [31:0]          imm;
    logic [31:0]          exp;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [OpCodeLen-1:0] op, input logic [OpSelLen-1:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                               input logic [31:0] pc, input logic ji);
    ex_aluop     = op;
    ex_alusel    = sel;
    ex_reg1      = r1;
    ex_reg2      = r2;
    ex_Imm       = imm;
    ex_pc        = pc;
    jump_i       = ji;
    ex_rd        = 5'd7;
    ex_rd_enable = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Counts stalled cycles at negedges; returns at the first non-stalled negedge or when the budget runs out.
  task automatic runMulti(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall_req) break;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{EXE_ADDI,  SEL_ARITH, 32'h5,        32'h0,        32'hFFFFFFF9, 32'hFFFFFFFE};
    vecs[1]  = '{EXE_SUB,   SEL_ARITH, 32'h3,        32'h5,        32'h0,        32'hFFFFFFFE};
    vecs[2]  = '{EXE_SLT,   SEL_ARITH, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h1};
    vecs[3]  = '{EXE_SLTU,  SEL_ARITH, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0};
    vecs[4]  = '{EXE_SRAI,  SEL_SHIFT, 32'h80000000, 32'h0,        32'h404,      32'hF8000000};
    vecs[5]  = '{EXE_SLL,   SEL_SHIFT, 32'h3,        32'h24,       32'h0,        32'h30};
    vecs[6]  = '{EXE_LUI,   SEL_ARITH, 32'h0,        32'h0,        32'h12345000, 32'h12345000};
    vecs[7]  = '{EXE_DIVU,  MULDIV_OP, 32'h4D2,      32'h0,        32'h0,        32'hFFFFFFFF};
    vecs[8]  = '{EXE_REMU,  MULDIV_OP, 32'h4D2,      32'h0,        32'h0,        32'h4D2};
    vecs[9]  = '{EXE_DIV,   MULDIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    vecs[10] = '{EXE_REM,   MULDIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0};

    rst = 1'b1;
    rdy = 1'b1;
    stall = '0;
    applyStimulus(EXE_ADDI, SEL_ARITH, 32'h5, 32'h0, 32'hFFFFFFF9, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rstRdData",   rd_data_o,   32'h0);
    checkOutput("rstRdEnable", rd_enable_o, 1'b0);
    checkOutput("rstAluop",    aluop_o,     EXE_NOP);
    checkOutput("rstStall",    stall_req,   1'b0);
    checkOutput("rstTarget",   jump_target, 32'h0);
    nextCycle();
    rst = 1'b0;

    @(negedge clk);
    checkOutput("addiRd",      rd_data_o,  32'hFFFFFFFE);
    checkOutput("addiStall",   stall_req,  1'b0);
    checkOutput("addiRdAddr",  rd_o,       5'd7);
    checkOutput("addiMemAddr", mem_addr_o, 32'hFFFFFFFE);
    checkOutput("addiAluop",   aluop_o,    EXE_ADDI);

    nextCycle();
    applyStimulus(EXE_BEQ, SEL_JUMP, 32'h3, 32'h3, 32'h20, 32'h100, 1'b0);
    @(negedge clk);
    checkOutput("beqMistakeNt", jump_mistake, 1'b1);
    checkOutput("beqTarget",    jump_target,  32'h120);
    nextCycle();
    applyStimulus(EXE_BEQ, SEL_JUMP, 32'h3, 32'h3, 32'h20, 32'h100, 1'b1);
    @(negedge clk);
    checkOutput("beqMistakeT",  jump_mistake, 1'b0);
    checkOutput("beqTargetT",   jump_target,  32'h120);
    nextCycle();
    applyStimulus(EXE_BNE, SEL_JUMP, 32'h3, 32'h3, 32'h20, 32'h100, 1'b1);
    @(negedge clk);
    checkOutput("bneMistake",   jump_mistake, 1'b1);
    checkOutput("bneTarget",    jump_target,  32'h104);
    nextCycle();
    applyStimulus(EXE_JALR, SEL_JUMP, 32'h203, 32'h0, 32'h10, 32'h40, 1'b1);
    @(negedge clk);
    checkOutput("jalrMistake",  jump_mistake, 1'b1);
    checkOutput("jalrTarget",   jump_target,  32'h212);
    checkOutput("jalrLink",     rd_data_o,    32'h44);

    for (int i = 0; i < 11; i++) begin
      nextCycle();
      applyStimulus(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].imm, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0dRd", i),    rd_data_o, vecs[i].exp);
      checkOutput($sformatf("vec%0dStall", i), stall_req, 1'b0);
    end

    nextCycle();
    applyStimulus(EXE_DIV, MULDIV_OP, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 1'b0);
    runMulti(cycles);
    checkOutput("divCycles", cycles,    33);
    checkOutput("divRes",    rd_data_o, 32'hFFFFFFFD);
    nextCycle();
    applyStimulus(EXE_REM, MULDIV_OP, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 1'b0);
    runMulti(cycles);
    checkOutput("remCycles", cycles,    33);
    checkOutput("remRes",    rd_data_o, 32'hFFFFFFFF);

    nextCycle();
    applyStimulus(EXE_MULHU, MULDIV_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
    runMulti(cycles);
    checkOutput("mulhuCycles", cycles,    2);
    checkOutput("mulhuRes",    rd_data_o, 32'hFFFFFFFE);
    nextCycle();
    applyStimulus(EXE_MULHSU, MULDIV_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
    runMulti(cycles);
    checkOutput("mulhsuRes", rd_data_o, 32'hFFFFFFFF);
    nextCycle();
    applyStimulus(EXE_MUL, MULDIV_OP, 32'h7, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b0);
    runMulti(cycles);
    checkOutput("mulRes", rd_data_o, 32'hFFFFFFEB);

    nextCycle();
    applyStimulus(EXE_DIVU, MULDIV_OP, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall_req) break;
      cycles++;
      rdy = !(cycles >= 5 && cycles < 8);
    end
    rdy = 1'b1;
    checkOutput("rdyCycles", cycles,    36);
    checkOutput("rdyRes",    rd_data_o, 32'hE);

    nextCycle();
    applyStimulus(EXE_DIV, MULDIV_OP, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0);
    cycles = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (stall_req) cycles++;
    end
    checkOutput("preRstCycles", cycles, 11);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(EXE_NOP, SEL_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("abortStall", stall_req,   1'b0);
    checkOutput("abortState", dut.r_state, EX_IDLE);
    checkOutput("abortRd",    rd_data_o,   32'h0);

    nextCycle();
    applyStimulus(EXE_MUL, MULDIV_OP, 32'd6, 32'd7, 32'h0, 32'h0, 1'b0);
    runMulti(cycles);
    checkOutput("holdMulCycles", cycles, 2);
    stall = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("holdRd%0d", i),    rd_data_o, 32'h2A);
      checkOutput($sformatf("holdStall%0d", i), stall_req, 1'b0);
    end
    checkOutput("holdState", dut.r_state, EX_DONE);
    stall = '0;
    nextCycle();
    applyStimulus(EXE_ADD, SEL_ARITH, 32'd2, 32'd3, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("afterHoldRd",    rd_data_o, 32'h5);
    checkOutput("afterHoldStall", stall_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
